// File: rtl/prod_accum_pkg.sv
// Shared types and width helpers for the product accumulator datapath.
package prod_accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } accum_state_e;

   // Width of an overflow-free sum of len unsigned (2*dw)-bit products.
   function automatic int unsigned sum_width(input int unsigned dw, input int unsigned len);
      return (len > 1) ? (2 * dw + $clog2(len)) : (2 * dw);
   endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Stream bundle between a multiplier stage, prod_accum and its consumer.
//   flush      : synchronous discard of the partial group
//   in_valid   : product beat present        in_ready  : beat accepted this cycle
//   in_product : 2*DW-bit unsigned product
//   out_valid  : out_sum holds a completed group
//   out_ready  : consumer takes out_sum      out_sum   : SW-bit group sum
interface prod_accum_if
   import prod_accum_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned LEN = 4
) ();
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = sum_width(DW, LEN);

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_product;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_sum;

   // Producer/consumer side (wrapper or bench).
   modport master (
      output flush, in_valid, in_product, out_ready,
      input  in_ready, out_valid, out_sum
   );

   // Accumulator side.
   modport slave (
      input  flush, in_valid, in_product, out_ready,
      output in_ready, out_valid, out_sum
   );
endinterface

// File: rtl/prod_accum.sv
// Streaming accumulator: sums each group of LEN consecutive unsigned products
// into a full-precision result presented on a valid/ready output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   s     : prod_accum_if.slave stream bundle (flush, input beat, output sum)
// in_ready is combinational from out_ready while a result is held, so a take
// and the first beat of the next group can share a cycle (no bubbles).
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned LEN = 4
) (
   input logic          clk,
   input logic          rst_n,
   prod_accum_if.slave  s
);
   localparam int unsigned SW = sum_width(DW, LEN);
   localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

   if (LEN < 1) begin : g_bad_len
      $error("prod_accum: LEN must be >= 1");
   end

   accum_state_e  state;
   logic [SW-1:0] acc;
   logic [CW-1:0] cnt;
   logic [SW-1:0] out_sum;
   logic          accept;
   logic          take;
   logic          last;
   logic [SW-1:0] sum_next;

   assign s.in_ready  = (state == ACCUM) || s.out_ready;
   assign s.out_valid = (state == HOLD);
   assign s.out_sum   = out_sum;

   assign accept = s.in_valid && s.in_ready;
   assign take   = s.out_valid && s.out_ready;
   assign last   = (cnt == CW'(LEN - 1));

   // First beat of a group ignores whatever is left in acc.
   always_comb begin
      sum_next = ((cnt == '0) ? '0 : acc) + SW'(s.in_product);
   end

   // State, counter, accumulator and held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ACCUM;
         acc     <= '0;
         cnt     <= '0;
         out_sum <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (s.flush) begin
                  cnt <= '0;
               end else if (accept) begin
                  if (last) begin
                     out_sum <= sum_next;
                     cnt     <= '0;
                     state   <= HOLD;
                  end else begin
                     acc <= sum_next;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (take) begin
                  if (accept && !s.flush) begin
                     if (LEN == 1) begin
                        out_sum <= SW'(s.in_product);
                     end else begin
                        acc   <= SW'(s.in_product);
                        cnt   <= CW'(1);
                        state <= ACCUM;
                     end
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum: DW=8/LEN=4 (main), DW=16/LEN=4
// (maximum products) and DW=8/LEN=1 (echo) instances.
module tb_prod_accum;
   import prod_accum_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   prod_accum_if #(.DW(8),  .LEN(4)) a_if ();
   prod_accum_if #(.DW(16), .LEN(4)) b_if ();
   prod_accum_if #(.DW(8),  .LEN(1)) c_if ();

   prod_accum #(.DW(8),  .LEN(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .s(a_if.slave));
   prod_accum #(.DW(16), .LEN(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .s(b_if.slave));
   prod_accum #(.DW(8),  .LEN(1)) u_dut_c (.clk(clk), .rst_n(rst_n), .s(c_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One beat on the main instance; valid drops afterwards unless re-driven.
   task automatic send_a(input logic [15:0] p);
      a_if.in_valid   = 1'b1;
      a_if.in_product = p;
      step();
      a_if.in_valid   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      a_if.flush = 1'b0; a_if.in_valid = 1'b0; a_if.in_product = '0; a_if.out_ready = 1'b1;
      b_if.flush = 1'b0; b_if.in_valid = 1'b0; b_if.in_product = '0; b_if.out_ready = 1'b1;
      c_if.flush = 1'b0; c_if.in_valid = 1'b0; c_if.in_product = '0; c_if.out_ready = 1'b1;
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset state
      check("rst_in_ready",  64'(a_if.in_ready),  64'd1);
      check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("rst_out_sum",   64'(a_if.out_sum),   64'd0);

      // 1,2,3,4 back-to-back
      send_a(16'd1); send_a(16'd2); send_a(16'd3);
      check("lat_before_last", 64'(a_if.out_valid), 64'd0);
      send_a(16'd4);
      check("basic_valid", 64'(a_if.out_valid), 64'd1);
      check("basic_sum",   64'(a_if.out_sum),   64'd10);
      idle(1);
      check("basic_taken", 64'(a_if.out_valid), 64'd0);

      // Maximum DW=8 products
      for (int i = 0; i < 4; i++) send_a(16'd65025);
      check("max8_sum", 64'(a_if.out_sum), 64'd260100);
      idle(1);

      // Backpressure: result held, no beats consumed
      a_if.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_a(16'd1);
      check("bp_valid", 64'(a_if.out_valid), 64'd1);
      a_if.in_valid   = 1'b1;
      a_if.in_product = 16'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_sum_stable", 64'(a_if.out_sum),   64'd4);
         check("bp_valid_hold", 64'(a_if.out_valid), 64'd1);
         check("bp_in_ready",   64'(a_if.in_ready),  64'd0);
      end
      a_if.out_ready  = 1'b1;
      a_if.in_product = 16'd7;
      step();
      a_if.in_valid = 1'b0;
      check("bp_release_taken", 64'(a_if.out_valid), 64'd0);
      send_a(16'd1); send_a(16'd1); send_a(16'd1);
      check("bp_next_valid", 64'(a_if.out_valid), 64'd1);
      check("bp_next_sum",   64'(a_if.out_sum),   64'd10);
      idle(1);

      // Continuous stream 1..12, no bubbles
      for (int i = 1; i <= 12; i++) begin
         send_a(16'(i));
         if (i % 4 == 0) begin
            check("stream_valid", 64'(a_if.out_valid), 64'd1);
            check("stream_sum",   64'(a_if.out_sum),   64'(4 * i - 6));
         end else begin
            check("stream_gap", 64'(a_if.out_valid), 64'd0);
         end
      end
      idle(1);

      // Flush partial group, then flush during HOLD
      send_a(16'd5); send_a(16'd5);
      a_if.flush      = 1'b1;
      a_if.in_valid   = 1'b1;
      a_if.in_product = 16'd100;
      step();
      a_if.flush    = 1'b0;
      a_if.in_valid = 1'b0;
      check("flush_no_out", 64'(a_if.out_valid), 64'd0);
      for (int i = 0; i < 4; i++) send_a(16'd1);
      check("flush_valid", 64'(a_if.out_valid), 64'd1);
      check("flush_sum",   64'(a_if.out_sum),   64'd4);
      a_if.out_ready = 1'b0;
      a_if.flush     = 1'b1;
      step();
      a_if.flush = 1'b0;
      check("flush_hold_valid", 64'(a_if.out_valid), 64'd1);
      check("flush_hold_sum",   64'(a_if.out_sum),   64'd4);
      a_if.out_ready = 1'b1;
      step();
      check("flush_hold_taken", 64'(a_if.out_valid), 64'd0);

      // Asynchronous reset mid-group
      send_a(16'd3); send_a(16'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 64'(a_if.out_valid), 64'd0);
      idle(2);
      check("rst_mid_valid2", 64'(a_if.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) send_a(16'd2);
      check("rst_after_valid", 64'(a_if.out_valid), 64'd1);
      check("rst_after_sum",   64'(a_if.out_sum),   64'd8);
      idle(1);

      // DW=16 maximum products
      b_if.in_valid   = 1'b1;
      b_if.in_product = 32'hFFFE_0001;
      for (int i = 0; i < 4; i++) step();
      b_if.in_valid = 1'b0;
      check("max16_valid", 64'(b_if.out_valid), 64'd1);
      check("max16_sum",   64'(b_if.out_sum),   64'h3_FFF8_0004);
      idle(1);

      // LEN=1 echo
      begin
         logic [15:0] echo [3];
         echo[0] = 16'd17; echo[1] = 16'd200; echo[2] = 16'd65025;
         c_if.in_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            c_if.in_product = echo[i];
            step();
            check("len1_valid", 64'(c_if.out_valid), 64'd1);
            check("len1_sum",   64'(c_if.out_sum),   64'(echo[i]));
         end
         c_if.in_valid = 1'b0;
         step();
         check("len1_drain", 64'(c_if.out_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
